// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised raster timing generator. A divider turns iClk into a pixel
//   strobe; a column/line counter pair walks the raster once per strobe and
//   every output is registered from the *next* coordinates, so the sync and
//   active flags always line up with the coordinates shown beside them.
//
// Ports
//   iClk        system clock (single clock domain)
//   iRst        synchronous active-high reset
//   iEn         run enable; low freezes divider, counters and flags
//   oPixEn      pixel strobe, one iClk cycle per pixel period
//   oHS / oVS   syncs, driven at HS_POL / VS_POL while asserted
//   oActive     current coordinates lie in the visible area
//   oCountH/V   current column / line
//   oLineStart  oPixEn at column 0
//   oFrameStart oPixEn at column 0, line 0
`timescale 1ns/1ps

module vga_timing_gen #(
  parameter int   CNT_W    = 12,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_PW     = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_PW     = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CLK_DIV  = 1
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iEn,
  output logic             oPixEn,
  output logic             oHS,
  output logic             oVS,
  output logic             oActive,
  output logic [CNT_W-1:0] oCountH,
  output logic [CNT_W-1:0] oCountV,
  output logic             oLineStart,
  output logic             oFrameStart
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_PW + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_PW + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_PW);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_PW);
  localparam logic [DIV_W-1:0] PH_LAST  = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] phase;
  logic [DIV_W-1:0] phase_nxt;
  logic             pix_nxt;
  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;
  logic             hs_on;
  logic             vs_on;
  logic             active_nxt;

  // Next-state of divider and raster. The position only moves on an enabled
  // edge that closes a strobe cycle, so a freeze that swallows a strobe costs
  // one extra presentation of the held pixel rather than a skipped pixel.
  always_comb begin
    phase_nxt = phase;
    pix_nxt   = 1'b0;
    h_nxt     = oCountH;
    v_nxt     = oCountV;
    if (iEn) begin
      if (phase == PH_LAST) begin
        phase_nxt = '0;
        pix_nxt   = 1'b1;
      end else begin
        phase_nxt = phase + DIV_W'(1);
      end
      if (oPixEn) begin
        if (oCountH == H_LAST) begin
          h_nxt = '0;
          v_nxt = (oCountV == V_LAST) ? '0 : oCountV + CNT_W'(1);
        end else begin
          h_nxt = oCountH + CNT_W'(1);
        end
      end
    end
  end

  // Flags are decoded from the next coordinates and registered alongside
  // them, which gives zero skew between flags and counts.
  always_comb begin
    hs_on      = (h_nxt >= HS_START) && (h_nxt < HS_END);
    vs_on      = (v_nxt >= VS_START) && (v_nxt < VS_END);
    active_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      phase       <= '0;
      oPixEn      <= 1'b0;
      oCountH     <= '0;
      oCountV     <= '0;
      oHS         <= ~HS_POL;
      oVS         <= ~VS_POL;
      oActive     <= 1'b1;
      oLineStart  <= 1'b0;
      oFrameStart <= 1'b0;
    end else begin
      phase       <= phase_nxt;
      oPixEn      <= pix_nxt;
      oCountH     <= h_nxt;
      oCountV     <= v_nxt;
      oHS         <= hs_on ? HS_POL : ~HS_POL;
      oVS         <= vs_on ? VS_POL : ~VS_POL;
      oActive     <= active_nxt;
      oLineStart  <= pix_nxt && (h_nxt == '0);
      oFrameStart <= pix_nxt && (h_nxt == '0) && (v_nxt == '0);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Three generators on one clock: a small raster with active-low syncs and
//   CLK_DIV=1 (A), the same raster with active-high syncs and CLK_DIV=4 (B),
//   and the default 640x480 mode (C). A linear pixel-index model is compared
//   against every output of every instance each cycle; directed scenarios add
//   hand-computed expectations (periods, pulse counts, wraps, freeze, reset).
`timescale 1ns/1ps

module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  pix_o, hs_o, vs_o, act_o, ls_o, fs_o;
  logic [11:0] h_o [3];
  logic [11:0] v_o [3];

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_PW(4), .H_BP(3),
    .V_ACTIVE(8),  .V_FP(2), .V_PW(2), .V_BP(3),
    .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(1)
  ) dut_a (
    .iClk(clk), .iRst(rst), .iEn(en),
    .oPixEn(pix_o[0]), .oHS(hs_o[0]), .oVS(vs_o[0]), .oActive(act_o[0]),
    .oCountH(h_o[0]), .oCountV(v_o[0]),
    .oLineStart(ls_o[0]), .oFrameStart(fs_o[0])
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_PW(4), .H_BP(3),
    .V_ACTIVE(8),  .V_FP(2), .V_PW(2), .V_BP(3),
    .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(4)
  ) dut_b (
    .iClk(clk), .iRst(rst), .iEn(en),
    .oPixEn(pix_o[1]), .oHS(hs_o[1]), .oVS(vs_o[1]), .oActive(act_o[1]),
    .oCountH(h_o[1]), .oCountV(v_o[1]),
    .oLineStart(ls_o[1]), .oFrameStart(fs_o[1])
  );

  vga_timing_gen dut_c (
    .iClk(clk), .iRst(rst), .iEn(en),
    .oPixEn(pix_o[2]), .oHS(hs_o[2]), .oVS(vs_o[2]), .oActive(act_o[2]),
    .oCountH(h_o[2]), .oCountV(v_o[2]),
    .oLineStart(ls_o[2]), .oFrameStart(fs_o[2])
  );

  // Model geometry, one entry per instance.
  int m_ha [3] = '{16, 16, 640};
  int m_hf [3] = '{2, 2, 16};
  int m_hp [3] = '{4, 4, 96};
  int m_hb [3] = '{3, 3, 48};
  int m_va [3] = '{8, 8, 480};
  int m_vf [3] = '{2, 2, 10};
  int m_vp [3] = '{2, 2, 2};
  int m_vb [3] = '{3, 3, 33};
  bit m_hpol [3] = '{1'b0, 1'b1, 1'b0};
  bit m_vpol [3] = '{1'b0, 1'b1, 1'b0};
  int m_div  [3] = '{1, 4, 1};

  // Model state: enabled-edge phase, linear pixel index within the frame,
  // and whether the strobe is up.
  int m_ph  [3] = '{0, 0, 0};
  int m_idx [3] = '{0, 0, 0};
  bit m_pix [3] = '{1'b0, 1'b0, 1'b0};

  int n_cmp = 0;
  int n_bad = 0;

  function automatic int frame_len(int i);
    return (m_ha[i] + m_hf[i] + m_hp[i] + m_hb[i]) *
           (m_va[i] + m_vf[i] + m_vp[i] + m_vb[i]);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_ph[i]  <= 0;
        m_idx[i] <= 0;
        m_pix[i] <= 1'b0;
      end else if (en) begin
        m_ph[i]  <= (m_ph[i] + 1) % m_div[i];
        m_pix[i] <= ((m_ph[i] + 1) % m_div[i]) == 0;
        m_idx[i] <= m_pix[i] ? (m_idx[i] + 1) % frame_len(i) : m_idx[i];
      end else begin
        m_pix[i] <= 1'b0;
      end
    end
  end

  // {pix, hs, vs, active, h[11:0], v[11:0], line_start, frame_start}
  function automatic logic [29:0] expect_vec(int i);
    int  ht, h, v, hs0, vs0;
    bit  hs_on, vs_on, act, p;
    ht    = m_ha[i] + m_hf[i] + m_hp[i] + m_hb[i];
    h     = m_idx[i] % ht;
    v     = m_idx[i] / ht;
    hs0   = m_ha[i] + m_hf[i];
    vs0   = m_va[i] + m_vf[i];
    hs_on = (h >= hs0) && (h < hs0 + m_hp[i]);
    vs_on = (v >= vs0) && (v < vs0 + m_vp[i]);
    act   = (h < m_ha[i]) && (v < m_va[i]);
    p     = m_pix[i];
    return {p, hs_on ? m_hpol[i] : ~m_hpol[i], vs_on ? m_vpol[i] : ~m_vpol[i],
            act, 12'(h), 12'(v), p && (h == 0), p && (m_idx[i] == 0)};
  endfunction

  function automatic logic [29:0] got_vec(int i);
    return {pix_o[i], hs_o[i], vs_o[i], act_o[i], h_o[i], v_o[i], ls_o[i], fs_o[i]};
  endfunction

  // Advance one cycle and compare all instances against the model.
  task automatic step();
    logic [29:0] g, e;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      g = got_vec(i);
      e = expect_vec(i);
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        if (n_bad <= 40)
          $display("FAIL model_%0d @%0t: got %h expected %h", i, $time, g, e);
      end
    end
  endtask

  task automatic check(string nm, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  initial begin
    int cyc, n_ls, n_hs, n_vs, n_act, last_h, last_v, last_p, gaps, bad;

    // Reset state
    rst = 1'b1; en = 1'b0;
    step(); step();
    check("rst_h_a",   int'(h_o[0]), 0);
    check("rst_v_a",   int'(v_o[0]), 0);
    check("rst_pix_a", int'(pix_o[0]), 0);
    check("rst_hs_a",  int'(hs_o[0]), 1);
    check("rst_act_a", int'(act_o[0]), 1);
    check("rst_hs_b",  int'(hs_o[1]), 0);

    // Edge 1 and one full frame of A
    rst = 1'b0; en = 1'b1;
    step();
    check("e1_fs_a",  int'(fs_o[0]), 1);
    check("e1_ls_a",  int'(ls_o[0]), 1);
    check("e1_pix_b", int'(pix_o[1]), 0);
    check("e1_fs_c",  int'(fs_o[2]), 1);
    cyc = 0; n_ls = 0; n_hs = 0; n_vs = 0; n_act = 0; last_h = -1; last_v = -1;
    do begin
      if (ls_o[0]) n_ls++;
      if (pix_o[0] && !hs_o[0]) n_hs++;
      if (pix_o[0] && !vs_o[0]) n_vs++;
      if (pix_o[0] && act_o[0]) begin
        n_act++; last_h = int'(h_o[0]); last_v = int'(v_o[0]);
      end
      step();
      cyc++;
    end while (!fs_o[0] && cyc < 2000);
    check("a_frame_period", cyc, 375);
    check("a_line_starts", n_ls, 15);
    check("a_hs_low_pix", n_hs, 60);
    check("a_vs_low_pix", n_vs, 50);
    check("a_active_pix", n_act, 128);
    check("a_last_active_h", last_h, 15);
    check("a_last_active_v", last_v, 7);

    // Divider: B with CLK_DIV=4
    rst = 1'b1; step(); rst = 1'b0;
    cyc = 0;
    do begin step(); cyc++; end while (!fs_o[1] && cyc < 20);
    check("b_first_fs_edge", cyc, 4);
    cyc = 0; n_act = 0; n_hs = 0; last_p = -1; gaps = 0;
    do begin
      if (pix_o[1]) begin
        n_act++;
        if (hs_o[1]) n_hs++;
        if (last_p >= 0 && cyc - last_p != 4) gaps++;
        last_p = cyc;
      end
      step();
      cyc++;
    end while (!fs_o[1] && cyc < 4000);
    check("b_frame_period", cyc, 1500);
    check("b_pix_per_frame", n_act, 375);
    check("b_hs_high_pix", n_hs, 60);
    check("b_bad_pix_gaps", gaps, 0);

    // Default mode, first line wrap of C
    rst = 1'b1; step(); rst = 1'b0;
    n_hs = 0;
    for (int e = 1; e <= 800; e++) begin
      step();
      if (pix_o[2] && v_o[2] == 12'd0 && !hs_o[2]) n_hs++;
    end
    check("c_e800_h", int'(h_o[2]), 799);
    check("c_e800_v", int'(v_o[2]), 0);
    check("c_hs_low_line0", n_hs, 96);
    step();
    check("c_wrap_h", int'(h_o[2]), 0);
    check("c_wrap_v", int'(v_o[2]), 1);
    check("c_wrap_ls", int'(ls_o[2]), 1);

    // Freeze A at (10,5)
    rst = 1'b1; step(); rst = 1'b0;
    cyc = 0;
    do begin step(); cyc++; end
    while (!(h_o[0] == 12'd10 && v_o[0] == 12'd5 && pix_o[0]) && cyc < 500);
    check("frz_reached", cyc, 136);
    en = 1'b0;
    bad = 0;
    repeat (50) begin
      step();
      if (h_o[0] != 12'd10 || v_o[0] != 12'd5 || pix_o[0] || ls_o[0] || fs_o[0]) bad++;
    end
    check("frz_hold_violations", bad, 0);
    en = 1'b1;
    cyc = 0;
    do begin step(); cyc++; end
    while (h_o[0] == 12'd10 && v_o[0] == 12'd5 && cyc < 20);
    check("frz_next_h", int'(h_o[0]), 11);
    check("frz_next_v", int'(v_o[0]), 5);

    // Reset A mid-frame at (19,10) with both syncs asserted
    rst = 1'b1; step(); rst = 1'b0;
    cyc = 0;
    do begin step(); cyc++; end
    while (!(h_o[0] == 12'd19 && v_o[0] == 12'd10) && cyc < 500);
    check("mid_hs_asserted", int'(hs_o[0]), 0);
    check("mid_vs_asserted", int'(vs_o[0]), 0);
    rst = 1'b1;
    step();
    check("mid_rst_h",   int'(h_o[0]), 0);
    check("mid_rst_v",   int'(v_o[0]), 0);
    check("mid_rst_hs",  int'(hs_o[0]), 1);
    check("mid_rst_vs",  int'(vs_o[0]), 1);
    check("mid_rst_act", int'(act_o[0]), 1);
    check("mid_rst_pix", int'(pix_o[0]), 0);
    check("mid_rst_fs",  int'(fs_o[0]), 0);
    rst = 1'b0;
    step();
    check("mid_e1_fs", int'(fs_o[0]), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
